mlaccel_xspi_slave: RTL and testbench

- Parametrised successor to the host-link slave front end.
- Syncs host CSB/SCLK/IO[3:0] into the `clock` domain and supports 1-, 2- and 4-lane framing, selectable per frame.
- Converts nibble/bit streams to bytes (din stream) and drives response bytes back from an internal TX FIFO after a programmable dummy turnaround.
- Sits between the pad buffers and the command state machine; reports ready and error on dedicated pins.

---
 rtl/mlaccel_xspi_pkg.sv | 27 ++
 rtl/mlaccel_sync_fifo.sv | 50 +++++
 rtl/mlaccel_xspi_slave.sv | 168 ++++++++++++++++
 tb/tb_mlaccel_xspi_slave.sv | 214 +++++++++++++++++++++
 4 files changed

// File: rtl/mlaccel_xspi_pkg.sv
// Shared encodings and helpers for the xSPI host-link slave front end.
package mlaccel_xspi_pkg;

  localparam logic [1:0] MODE_X1 = 2'd0;
  localparam logic [1:0] MODE_X2 = 2'd1;
  localparam logic [1:0] MODE_X4 = 2'd2;

  typedef enum logic [1:0] {IDLE, RX, TURN, TX} xspi_state_t;

  // Output-enable mask per lane mode; the reserved mode behaves as x4.
  function automatic logic [3:0] lane_mask(input logic [1:0] m);
    case (m)
      MODE_X1: return 4'b0010;
      MODE_X2: return 4'b0011;
      default: return 4'b1111;
    endcase
  endfunction

  function automatic logic [3:0] lane_cnt(input logic [1:0] m);
    case (m)
      MODE_X1: return 4'd1;
      MODE_X2: return 4'd2;
      default: return 4'd4;
    endcase
  endfunction

endpackage

// File: rtl/mlaccel_sync_fifo.sv
// Small synchronous FIFO with first-word fall-through read and a flush input.
module mlaccel_sync_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 4
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             flush,
  input  logic             push,
  input  logic [WIDTH-1:0] wdata,
  input  logic             pop,
  output logic [WIDTH-1:0] rdata,
  output logic             full,
  output logic             empty
);
  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wptr, rptr;
  logic [AW:0]      count;
  logic             do_push, do_pop;

  assign empty   = (count == '0);
  assign full    = (count == (AW+1)'(DEPTH));
  assign do_pop  = pop && !empty;
  // A pop in the same cycle frees a slot, so a full FIFO can still take a push.
  assign do_push = push && (!full || do_pop);
  assign rdata   = mem[rptr];

  always_ff @(posedge clock) begin
    if (do_push) mem[wptr] <= wdata;
  end

  always_ff @(posedge clock) begin
    if (reset || flush) begin
      wptr  <= '0;
      rptr  <= '0;
      count <= '0;
    end else begin
      if (do_push) wptr <= wptr + AW'(1);
      if (do_pop)  rptr <= rptr + AW'(1);
      case ({do_push, do_pop})
        2'b10:   count <= count + (AW+1)'(1);
        2'b01:   count <= count - (AW+1)'(1);
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/mlaccel_xspi_slave.sv
// xSPI slave front end: syncs the host pins, deserialises x1/x2/x4 frames into
// bytes and serialises TX FIFO bytes back after a dummy turnaround.
module mlaccel_xspi_slave #(
  parameter int SYNC_STAGES = 2,
  parameter int TX_DEPTH    = 4,
  parameter int DUMMY_W     = 4
) (
  input  logic               clock,
  input  logic               reset,
  input  logic               csb_di,
  input  logic               sclk_di,
  input  logic [3:0]         io_di,
  output logic [3:0]         io_do,
  output logic [3:0]         io_oe,
  output logic               rdy_do,
  output logic               err_do,
  input  logic [1:0]         mode,
  input  logic [DUMMY_W-1:0] dummy,
  input  logic               busy,
  output logic               din_valid,
  output logic               din_start,
  output logic [7:0]         din_data,
  input  logic               turnaround,
  input  logic               dout_valid,
  output logic               dout_ready,
  input  logic [7:0]         dout_data
);
  import mlaccel_xspi_pkg::*;

  logic [SYNC_STAGES-1:0]  csb_sync, sclk_sync;
  logic [SYNC_STAGES:0][3:0] io_sync;
  logic        csb_q, csb_s, csb_rise, sclk_rise, sclk_fall;
  logic [3:0]  rx_io, lanes, tx_cnt, bit_cnt;
  xspi_state_t state, state_nxt;
  logic [1:0]  mode_q;
  logic [7:0]  shreg, rx_next, tx_sh, fifo_rdata;
  logic [DUMMY_W-1:0] dcnt;
  logic        first_byte, err, lock, ready_q;
  logic        fifo_full, fifo_empty, fifo_pop;

  // Sync chains are deliberately not reset so lock sees the true CSB level.
  always_ff @(posedge clock) begin
    csb_sync  <= {csb_sync[SYNC_STAGES-2:0], csb_di};
    sclk_sync <= {sclk_sync[SYNC_STAGES-2:0], sclk_di};
    io_sync   <= {io_sync[SYNC_STAGES-1:0], io_di};
    csb_q     <= csb_sync[SYNC_STAGES-1];
  end

  assign csb_s     = csb_sync[SYNC_STAGES-1];
  assign csb_rise  = csb_s && !csb_q;
  assign sclk_rise = sclk_sync[SYNC_STAGES-2] && !sclk_sync[SYNC_STAGES-1];
  assign sclk_fall = !sclk_sync[SYNC_STAGES-2] && sclk_sync[SYNC_STAGES-1];
  assign rx_io     = io_sync[SYNC_STAGES];
  assign lanes     = lane_cnt(mode_q);

  always_ff @(posedge clock) begin
    if (reset) state <= IDLE;
    else       state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (!csb_s && !lock) state_nxt = RX;
      RX:      if (turnaround) state_nxt = TURN;
      TURN:    if (dcnt == '0 || (sclk_fall && dcnt == DUMMY_W'(1))) state_nxt = TX;
      default: state_nxt = state;
    endcase
    if (csb_rise) state_nxt = IDLE;
  end

  always_comb begin
    case (mode_q)
      MODE_X1: rx_next = {shreg[6:0], rx_io[0]};
      MODE_X2: rx_next = {shreg[5:0], rx_io[1:0]};
      default: rx_next = {shreg[3:0], rx_io};
    endcase
  end

  always_comb begin
    io_oe = 4'b0000;
    io_do = 4'b0000;
    if (state == TX) begin
      io_oe = lane_mask(mode_q);
      case (mode_q)
        MODE_X1: io_do = {2'b00, tx_sh[7], 1'b0};
        MODE_X2: io_do = {2'b00, tx_sh[7:6]};
        default: io_do = tx_sh[7:4];
      endcase
    end
  end

  assign fifo_pop   = (state == TX) && sclk_fall && (tx_cnt == 4'd0) && !csb_rise;
  assign dout_ready = ready_q && !fifo_full && !csb_rise;

  always_ff @(posedge clock) begin
    if (reset) begin
      mode_q <= MODE_X1;  shreg <= '0;  bit_cnt <= '0;  first_byte <= 1'b1;
      dcnt <= '0;  tx_sh <= '0;  tx_cnt <= '0;  err <= 1'b0;  lock <= 1'b1;
      ready_q <= 1'b0;  rdy_do <= 1'b0;  err_do <= 1'b0;
      din_valid <= 1'b0;  din_start <= 1'b0;  din_data <= '0;
    end else begin
      din_valid <= 1'b0;
      din_start <= 1'b0;
      ready_q   <= 1'b1;
      rdy_do    <= !busy;
      err_do    <= err;
      if (csb_s) lock <= 1'b0;
      if (csb_rise) begin
        bit_cnt <= '0;
        err     <= 1'b0;
      end else begin
        case (state)
          IDLE: begin
            mode_q     <= mode;
            bit_cnt    <= '0;
            tx_cnt     <= '0;
            first_byte <= 1'b1;
          end
          RX: begin
            if (turnaround) begin
              dcnt    <= dummy;
              bit_cnt <= '0;
            end else if (sclk_rise) begin
              shreg <= rx_next;
              if (bit_cnt + lanes == 4'd8) begin
                din_data   <= rx_next;
                din_valid  <= 1'b1;
                din_start  <= first_byte;
                first_byte <= 1'b0;
                bit_cnt    <= '0;
              end else begin
                bit_cnt <= bit_cnt + lanes;
              end
            end
          end
          TURN: if (sclk_fall && dcnt != '0) dcnt <= dcnt - DUMMY_W'(1);
          default: begin
            // Byte boundary: load the next byte, or 0xFF with an underrun flag.
            if (sclk_fall) begin
              if (tx_cnt == 4'd0) begin
                tx_sh  <= fifo_empty ? 8'hFF : fifo_rdata;
                tx_cnt <= 4'd8 - lanes;
                if (fifo_empty) err <= 1'b1;
              end else begin
                tx_sh  <= tx_sh << lanes;
                tx_cnt <= tx_cnt - lanes;
              end
            end
          end
        endcase
      end
    end
  end

  mlaccel_sync_fifo #(.WIDTH(8), .DEPTH(TX_DEPTH)) u_tx_fifo (
    .clock (clock),
    .reset (reset),
    .flush (csb_rise),
    .push  (dout_valid && dout_ready),
    .wdata (dout_data),
    .pop   (fifo_pop),
    .rdata (fifo_rdata),
    .full  (fifo_full),
    .empty (fifo_empty)
  );

endmodule

// File: tb/tb_mlaccel_xspi_slave.sv
// Scoreboard bench for mlaccel_xspi_slave: directed host frames, queued expectations.
module tb_mlaccel_xspi_slave;

  logic       clock = 1'b0;
  logic       reset = 1'b1;
  logic       csb_di = 1'b1, sclk_di = 1'b0;
  logic [3:0] io_di = 4'h0, io_do, io_oe, dummy = 4'h0;
  logic       rdy_do, err_do, busy = 1'b0;
  logic [1:0] mode = 2'd0;
  logic       din_valid, din_start, turnaround = 1'b0;
  logic [7:0] din_data, dout_data = 8'h00;
  logic       dout_valid = 1'b0, dout_ready;

  mlaccel_xspi_slave dut (
    .clock(clock), .reset(reset), .csb_di(csb_di), .sclk_di(sclk_di),
    .io_di(io_di), .io_do(io_do), .io_oe(io_oe), .rdy_do(rdy_do),
    .err_do(err_do), .mode(mode), .dummy(dummy), .busy(busy),
    .din_valid(din_valid), .din_start(din_start), .din_data(din_data),
    .turnaround(turnaround), .dout_valid(dout_valid),
    .dout_ready(dout_ready), .dout_data(dout_data)
  );

  always #5 clock = ~clock;

  typedef struct packed {logic [7:0] data; logic start;} din_t;
  din_t       din_q[$];
  logic [3:0] tx_q[$];
  logic [3:0] tx_mask = 4'hF;
  logic       tx_chk = 1'b0;
  int         errors = 0, checks = 0;

  task automatic chk(input string name, input logic [7:0] act, input logic [7:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %02h expected %02h", name, act, exp);
    end
  endtask

  // Monitor: received bytes
  always @(negedge clock) begin
    if (din_valid) begin
      din_t e;
      if (din_q.size() == 0) begin
        checks++; errors++;
        $display("FAIL din_unexpected: got %02h expected no byte", din_data);
      end else begin
        e = din_q.pop_front();
        chk("din_data", din_data, e.data);
        chk("din_start", {7'b0, din_start}, {7'b0, e.start});
      end
    end
  end

  // Monitor: the host samples the output lanes on each SCLK rise
  always @(posedge sclk_di) begin
    if (tx_chk) begin
      logic [3:0] e;
      if (tx_q.size() == 0) begin
        checks++; errors++;
        $display("FAIL tx_unexpected: got %h expected no data", io_do);
      end else begin
        e = tx_q.pop_front();
        chk("tx_io", {4'b0, io_do & tx_mask}, {4'b0, e});
      end
    end
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  task automatic half(); repeat (6) @(negedge clock); endtask
  task automatic pulse(); sclk_di = 1'b1; half(); sclk_di = 1'b0; half(); endtask
  task automatic rx_unit(input logic [3:0] v); io_di = v; half(); pulse(); endtask
  task automatic csb_low(input logic [1:0] m); mode = m; csb_di = 1'b0; half(); endtask
  task automatic csb_high(); csb_di = 1'b1; half(); sclk_di = 1'b0; half(); endtask
  task automatic exp_din(input logic [7:0] d, input logic s);
    din_t e; e.data = d; e.start = s; din_q.push_back(e);
  endtask
  task automatic push_fifo(input logic [7:0] d);
    @(negedge clock); dout_valid = 1'b1; dout_data = d;
    @(negedge clock); dout_valid = 1'b0;
  endtask

  // Turnaround, dummy falls, then the fall that loads the first TX byte.
  task automatic tx_start(input int n, input logic [3:0] mask);
    dummy = 4'(n);
    @(negedge clock); turnaround = 1'b1;
    @(negedge clock); turnaround = 1'b0;
    half();
    for (int i = 0; i < n; i++) begin
      pulse();
      if (i < n - 1) chk("io_oe_dummy", {4'b0, io_oe}, 8'h00);
    end
    chk("io_oe_tx", {4'b0, io_oe}, {4'b0, mask});
    pulse();
    tx_mask = mask;
    tx_chk  = 1'b1;
  endtask

  task automatic tx_clock(input int units);
    repeat (units - 1) pulse();
    sclk_di = 1'b1;
    half();
    tx_chk = 1'b0;
  endtask

  initial begin
    // Reset state
    repeat (3) @(negedge clock);
    chk("rst_dout_ready", {7'b0, dout_ready}, 8'h00);
    chk("rst_io_oe", {4'b0, io_oe}, 8'h00);
    chk("rst_io_do", {4'b0, io_do}, 8'h00);
    chk("rst_err_do", {7'b0, err_do}, 8'h00);
    chk("rst_rdy_do", {7'b0, rdy_do}, 8'h00);
    chk("rst_din_valid", {7'b0, din_valid}, 8'h00);
    reset = 1'b0;
    repeat (3) @(negedge clock);
    chk("post_rst_dout_ready", {7'b0, dout_ready}, 8'h01);
    chk("post_rst_rdy_do", {7'b0, rdy_do}, 8'h01);
    busy = 1'b1;
    repeat (3) @(negedge clock);
    chk("busy_rdy_do", {7'b0, rdy_do}, 8'h00);
    busy = 1'b0;
    half();

    // x4 receive: 2,1,0,0,1,0
    exp_din(8'h21, 1'b1); exp_din(8'h00, 1'b0); exp_din(8'h10, 1'b0);
    csb_low(2'd2);
    rx_unit(4'h2); rx_unit(4'h1); rx_unit(4'h0); rx_unit(4'h0); rx_unit(4'h1); rx_unit(4'h0);
    csb_high();
    chk("x4_din_pending", 8'(din_q.size()), 8'h00);

    // x1 receive 0xA5 (idle lanes carry noise), then a byte cut after 5 bits
    exp_din(8'hA5, 1'b1);
    csb_low(2'd0);
    rx_unit(4'b1011); rx_unit(4'b0110); rx_unit(4'b1111); rx_unit(4'b0000);
    rx_unit(4'b1010); rx_unit(4'b0001); rx_unit(4'b1110); rx_unit(4'b0101);
    rx_unit(4'h1); rx_unit(4'h1); rx_unit(4'h0); rx_unit(4'h1); rx_unit(4'h1);
    csb_high();
    chk("x1_cut_pending", 8'(din_q.size()), 8'h00);
    exp_din(8'h81, 1'b1);
    csb_low(2'd0);
    rx_unit(4'h1); rx_unit(4'h0); rx_unit(4'h0); rx_unit(4'h0);
    rx_unit(4'h0); rx_unit(4'h0); rx_unit(4'h0); rx_unit(4'h1);
    csb_high();
    chk("x1_restart_pending", 8'(din_q.size()), 8'h00);

    // x2: rx 0x20, dummy 2, transmit 0x3C then 0xFF
    push_fifo(8'h3C); push_fifo(8'hFF);
    exp_din(8'h20, 1'b1);
    tx_q = '{4'h0, 4'h3, 4'h3, 4'h0, 4'h3, 4'h3, 4'h3, 4'h3};
    csb_low(2'd1);
    rx_unit(4'b1100); rx_unit(4'b0110); rx_unit(4'b1000); rx_unit(4'b0100);
    tx_start(2, 4'b0011);
    tx_clock(8);
    chk("x2_err_do", {7'b0, err_do}, 8'h00);
    chk("x2_tx_pending", 8'(tx_q.size()), 8'h00);
    csb_high();
    chk("x2_io_oe_idle", {4'b0, io_oe}, 8'h00);

    // x4 underrun: one byte queued, two clocked out
    tx_q = '{4'h5, 4'hA, 4'hF, 4'hF};
    csb_low(2'd2);
    push_fifo(8'h5A);
    tx_start(0, 4'hF);
    tx_clock(4);
    chk("underrun_err_do", {7'b0, err_do}, 8'h01);
    chk("underrun_tx_pending", 8'(tx_q.size()), 8'h00);
    csb_high();
    chk("csb_err_do_clear", {7'b0, err_do}, 8'h00);
    chk("csb_io_oe_clear", {4'b0, io_oe}, 8'h00);

    // FIFO full: four accepted, fifth refused, pop reopens a slot
    for (int i = 1; i <= 4; i++) begin
      chk("fifo_ready_pre", {7'b0, dout_ready}, 8'h01);
      push_fifo(8'(i * 8'h11));
    end
    chk("fifo_full_ready", {7'b0, dout_ready}, 8'h00);
    push_fifo(8'h99);
    tx_q = '{4'h1, 4'h1, 4'h2, 4'h2, 4'h3, 4'h3, 4'h4, 4'h4, 4'h5, 4'h5};
    csb_low(2'd2);
    chk("fifo_full_ready_rx", {7'b0, dout_ready}, 8'h00);
    tx_start(0, 4'hF);
    chk("fifo_pop_ready", {7'b0, dout_ready}, 8'h01);
    push_fifo(8'h55);
    tx_clock(10);
    chk("fifo_err_do", {7'b0, err_do}, 8'h00);
    chk("fifo_tx_pending", 8'(tx_q.size()), 8'h00);
    csb_high();

    // Reset mid-frame locks out the rest of that frame
    exp_din(8'h21, 1'b1);
    csb_low(2'd2);
    rx_unit(4'h2); rx_unit(4'h1);
    @(negedge clock); reset = 1'b1;
    repeat (3) @(negedge clock); reset = 1'b0;
    rx_unit(4'h3); rx_unit(4'h4); rx_unit(4'h5); rx_unit(4'h6);
    csb_high();
    chk("lock_pending", 8'(din_q.size()), 8'h00);
    exp_din(8'h78, 1'b1);
    csb_low(2'd2);
    rx_unit(4'h7); rx_unit(4'h8);
    csb_high();
    chk("post_lock_pending", 8'(din_q.size()), 8'h00);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
